hazard_fwd_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage pipeline.
- Tracks the destination and source registers of in-flight instructions in internal shadow registers (E, M and W stages).
- Drives the 2-bit select lines of the Execute-stage forwarding 3:1 muxes: 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
- Generates the stall and flush controls for the pipeline registers, covering load-use hazards, taken branches/jumps and data-memory wait states.

---
 rtl/hazard_fwd_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: E/M/W shadow registers,
// forwarding selects, stall/flush control. Optional perf counters via HAZARD_PERF_EN.
module hazard_fwd_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              LoadD,
    input  logic              PCSrcE,
    input  logic              DMemReadyM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              StallW,
    output logic              FlushD,
    output logic              FlushE,
    output logic [CNT_W-1:0]  LuStallCnt,
    output logic [CNT_W-1:0]  FlushCnt,
    output logic [CNT_W-1:0]  MemStallCnt
);

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic [REG_AW-1:0] rs1_e_q, rs1_e_d;
    logic [REG_AW-1:0] rs2_e_q, rs2_e_d;
    logic [REG_AW-1:0] rd_e_q, rd_e_d;
    logic              reg_write_e_q, reg_write_e_d;
    logic              load_e_q, load_e_d;
    logic [REG_AW-1:0] rd_m_q, rd_m_d;
    logic              reg_write_m_q, reg_write_m_d;
    logic [REG_AW-1:0] rd_w_q, rd_w_d;
    logic              reg_write_w_q, reg_write_w_d;

    logic mem_stall;
    logic lw_stall;
    logic flush_d;
    logic flush_e;

    // Most recent producer wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              rw_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              rw_w
    );
        if (rw_m && (rd_m != '0) && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (rw_w && (rd_w != '0) && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        mem_stall = !DMemReadyM;
        lw_stall  = load_e_q && (rd_e_q != '0) && ((rd_e_q == Rs1D) || (rd_e_q == Rs2D))
                    && !PCSrcE && !mem_stall;
        flush_d   = PCSrcE && !mem_stall;
        flush_e   = (lw_stall || PCSrcE) && !mem_stall;
    end

    // Outputs are held at zero while reset is asserted.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        StallW    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        if (!reset) begin
            ForwardAE = fwd_sel(rs1_e_q, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
            ForwardBE = fwd_sel(rs2_e_q, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
            StallF    = lw_stall || mem_stall;
            StallD    = lw_stall || mem_stall;
            StallE    = mem_stall;
            StallM    = mem_stall;
            StallW    = mem_stall;
            FlushD    = flush_d;
            FlushE    = flush_e;
        end
    end

    // Shadow pipeline advance; a memory wait freezes every stage.
    always_comb begin
        rs1_e_d       = rs1_e_q;
        rs2_e_d       = rs2_e_q;
        rd_e_d        = rd_e_q;
        reg_write_e_d = reg_write_e_q;
        load_e_d      = load_e_q;
        rd_m_d        = rd_m_q;
        reg_write_m_d = reg_write_m_q;
        rd_w_d        = rd_w_q;
        reg_write_w_d = reg_write_w_q;
        if (!mem_stall) begin
            rd_w_d        = rd_m_q;
            reg_write_w_d = reg_write_m_q;
            rd_m_d        = rd_e_q;
            reg_write_m_d = reg_write_e_q;
            if (flush_e) begin
                rs1_e_d       = '0;
                rs2_e_d       = '0;
                rd_e_d        = '0;
                reg_write_e_d = 1'b0;
                load_e_d      = 1'b0;
            end else begin
                rs1_e_d       = Rs1D;
                rs2_e_d       = Rs2D;
                rd_e_d        = RdD;
                reg_write_e_d = RegWriteD;
                load_e_d      = LoadD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_e_q       <= '0;
            rs2_e_q       <= '0;
            rd_e_q        <= '0;
            reg_write_e_q <= 1'b0;
            load_e_q      <= 1'b0;
            rd_m_q        <= '0;
            reg_write_m_q <= 1'b0;
            rd_w_q        <= '0;
            reg_write_w_q <= 1'b0;
        end else begin
            rs1_e_q       <= rs1_e_d;
            rs2_e_q       <= rs2_e_d;
            rd_e_q        <= rd_e_d;
            reg_write_e_q <= reg_write_e_d;
            load_e_q      <= load_e_d;
            rd_m_q        <= rd_m_d;
            reg_write_m_q <= reg_write_m_d;
            rd_w_q        <= rd_w_d;
            reg_write_w_q <= reg_write_w_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] lu_cnt_q, flush_cnt_q, mem_cnt_q;

    // Event counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            lu_cnt_q    <= '0;
            flush_cnt_q <= '0;
            mem_cnt_q   <= '0;
        end else begin
            if (lw_stall)  lu_cnt_q    <= lu_cnt_q + CNT_W'(1);
            if (flush_d)   flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (mem_stall) mem_cnt_q   <= mem_cnt_q + CNT_W'(1);
        end
    end

    assign LuStallCnt  = reset ? '0 : lu_cnt_q;
    assign FlushCnt    = reset ? '0 : flush_cnt_q;
    assign MemStallCnt = reset ? '0 : mem_cnt_q;
`else
    assign LuStallCnt  = '0;
    assign FlushCnt    = '0;
    assign MemStallCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding, load-use, branch flush, memory wait, reset.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic       RegWriteD, LoadD, PCSrcE, DMemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
    logic [31:0] LuStallCnt, FlushCnt, MemStallCnt;

    int n_chk = 0;
    int n_bad = 0;

`ifdef HAZARD_PERF_EN
    localparam int unsigned EXP_LU  = 1;
    localparam int unsigned EXP_FL  = 2;
    localparam int unsigned EXP_MEM = 3;
`else
    localparam int unsigned EXP_LU  = 0;
    localparam int unsigned EXP_FL  = 0;
    localparam int unsigned EXP_MEM = 0;
`endif

    hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .LoadD(LoadD), .PCSrcE(PCSrcE), .DMemReadyM(DMemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE),
        .LuStallCnt(LuStallCnt), .FlushCnt(FlushCnt), .MemStallCnt(MemStallCnt)
    );

    always #5 clk = ~clk;

    logic [10:0] ctl_obs;
    assign ctl_obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] ex(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sfd, input logic smw,
                                       input logic fd, input logic fe);
        return {fa, fb, sfd, sfd, smw, smw, smw, fd, fe};
    endfunction

    task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic pc, input logic rdy);
        Rs1D = rs1; Rs2D = rs2; RdD = rd;
        RegWriteD = rw; LoadD = ld; PCSrcE = pc; DMemReadyM = rdy;
    endtask

    // Check outputs mid-cycle, then let the edge commit.
    task automatic cyc(input string tag, input logic [10:0] exp);
        @(negedge clk);
        chk(tag, 32'(ctl_obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic cnt_chk(input string tag, input int unsigned lu, input int unsigned fl,
                           input int unsigned mem);
        chk({tag, "_lu"}, LuStallCnt, lu);
        chk({tag, "_fl"}, FlushCnt, fl);
        chk({tag, "_mem"}, MemStallCnt, mem);
    endtask

    initial begin
        // Reset with busy inputs: everything must read zero.
        reset = 1'b1;
        drv(5'd5, 5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("rst0", 11'd0);
        cyc("rst1", 11'd0);
        reset = 1'b0;
        drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("idle", 11'd0);
        cnt_chk("cnt_init", 0, 0, 0);

        // add x5; sub x6,x5; or x8,x5 -> MEM then WB forwarding
        drv(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("add", ex(2'b00, 2'b00, 0, 0, 0, 0));
        drv(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("sub_in_d", ex(2'b00, 2'b00, 0, 0, 0, 0));
        drv(5'd5, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("fwd_mem", ex(2'b10, 2'b00, 0, 0, 0, 0));
        drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("fwd_wb", ex(2'b01, 2'b00, 0, 0, 0, 0));

        // Two writers of x3 then a consumer that itself writes x0
        drv(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("p1", ex(2'b00, 2'b00, 0, 0, 0, 0));
        drv(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("p2", ex(2'b00, 2'b00, 0, 0, 0, 0));
        drv(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("cons_in_d", ex(2'b00, 2'b00, 0, 0, 0, 0));
        drv(5'd0, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("m_prio", ex(2'b10, 2'b00, 0, 0, 0, 0));
        drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("x0_no_fwd", ex(2'b00, 2'b01, 0, 0, 0, 0));

        // lw x7 then consumer with rs2=x7
        drv(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("ld", ex(2'b00, 2'b00, 0, 0, 0, 0));
        drv(5'd0, 5'd7, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("lu_stall", ex(2'b00, 2'b00, 1, 0, 0, 1));
        cyc("lu_bubble", ex(2'b00, 2'b00, 0, 0, 0, 0));
        drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lu_fwd_wb", ex(2'b00, 2'b01, 0, 0, 0, 0));

        // Taken branch: the flushed instruction would otherwise forward from x12
        drv(5'd2, 5'd4, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("br_in_d", ex(2'b00, 2'b00, 0, 0, 0, 0));
        drv(5'd12, 5'd12, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("br_flush", ex(2'b00, 2'b00, 0, 0, 1, 1));
        drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("br_bubble", ex(2'b00, 2'b00, 0, 0, 0, 0));

        // Memory wait with a pending branch and load-use pair
        drv(5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("mw_prod", ex(2'b00, 2'b00, 0, 0, 0, 0));
        drv(5'd14, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("mw_ld", ex(2'b00, 2'b00, 0, 0, 0, 0));
        drv(5'd0, 5'd7, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("mw_wait0", ex(2'b10, 2'b00, 1, 1, 0, 0));
        cyc("mw_wait1", ex(2'b10, 2'b00, 1, 1, 0, 0));
        cyc("mw_wait2", ex(2'b10, 2'b00, 1, 1, 0, 0));
        DMemReadyM = 1'b1;
        cyc("mw_ready", ex(2'b10, 2'b00, 0, 0, 1, 1));
        cnt_chk("cnt_pre", EXP_LU, EXP_FL, EXP_MEM);

        // Load-use pending, then reset with a taken branch and a wait state
        drv(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("r_ld", ex(2'b00, 2'b00, 0, 0, 0, 0));
        drv(5'd0, 5'd7, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("r_lu_pre", 32'(ctl_obs), 32'(ex(2'b00, 2'b00, 1, 0, 0, 1)));
        reset = 1'b1;
        PCSrcE = 1'b1;
        DMemReadyM = 1'b0;
        #1;
        cnt_chk("cnt_in_rst", 0, 0, 0);
        cyc("r_mid", 11'd0);
        reset = 1'b0;
        drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cnt_chk("cnt_post", 0, 0, 0);
        cyc("r_idle", 11'd0);
        drv(5'd0, 5'd7, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("r_clean", 11'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
